bp_me_bo_prefetch_issuer: RTL and testbench

//  Downstream stage of the best-offset generator. Holds the current best offset (in cache lines)
//  and turns each demand-miss address into one prefetch address: miss line + offset.

---
 rtl/bp_me_bo_pkg.sv | 23 ++
 rtl/bp_me_bo_recent_filter.sv | 47 ++++
 rtl/bp_me_bo_prefetch_issuer.sv | 115 +++++++++++
 tb/tb_bp_me_bo_prefetch_issuer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_bo_pkg.sv
// Shared types and address-geometry helpers for the best-offset prefetch issuer.
package bp_me_bo_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_check = 2'd1,
    e_send  = 2'd2
  } bo_state_e;

  function automatic int lg_block_bytes_f(input int block_width);
    return $clog2(block_width / 8);
  endfunction

  function automatic int line_width_f(input int daddr_width, input int block_width);
    return daddr_width - lg_block_bytes_f(block_width);
  endfunction

  // Lowest line-address bit that belongs to the page number.
  function automatic int page_lsb_f(input int page_offset_width, input int block_width);
    return page_offset_width - lg_block_bytes_f(block_width);
  endfunction

endpackage

// File: rtl/bp_me_bo_recent_filter.sv
// Small FIFO-replacement filter of recently issued prefetch line addresses.
module bp_me_bo_recent_filter
  import bp_me_bo_pkg::*;
#(
  parameter int line_width_p    = 58,
  parameter int lg_filter_els_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [line_width_p-1:0] line_i,
  input  logic                    w_v_i,
  output logic                    hit_o
);

  localparam int els_lp = 1 << lg_filter_els_p;

  logic [els_lp-1:0]          valid_q;
  logic [els_lp-1:0]          match;
  logic [line_width_p-1:0]    tag_q [els_lp];
  logic [lg_filter_els_p-1:0] ptr_q;

  generate
    for (genvar gi = 0; gi < els_lp; gi++) begin : g_match
      assign match[gi] = valid_q[gi] & (tag_q[gi] == line_i);
    end
  endgenerate

  assign hit_o = |match;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (w_v_i && !hit_o) begin
      // A line already present is left alone so it keeps its FIFO position.
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= ptr_q + lg_filter_els_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_v_i && !hit_o) begin
      tag_q[ptr_q] <= line_i;
    end
  end

endmodule

// File: rtl/bp_me_bo_prefetch_issuer.sv
// Turns each demand miss into at most one prefetch at miss line + best offset,
// dropping page crossers, recent duplicates and zero-offset candidates.
module bp_me_bo_prefetch_issuer
  import bp_me_bo_pkg::*;
#(
  parameter int daddr_width_p       = 64,
  parameter int lg_offsets_p        = 6,
  parameter int block_width_p       = 512,
  parameter int page_offset_width_p = 12,
  parameter int lg_filter_els_p     = 2,
  parameter int ctr_width_p         = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [daddr_width_p-1:0] miss_addr_i,
  input  logic                     miss_v_i,
  output logic                     miss_ready_and_o,
  input  logic [lg_offsets_p-1:0]  offset_i,
  input  logic                     offset_v_i,
  output logic [daddr_width_p-1:0] pf_addr_o,
  output logic                     pf_v_o,
  input  logic                     pf_ready_and_i,
  output logic [ctr_width_p-1:0]   issued_count_o,
  output logic [ctr_width_p-1:0]   dropped_count_o
);

  localparam int lg_block_bytes_lp = lg_block_bytes_f(block_width_p);
  localparam int line_width_lp     = line_width_f(daddr_width_p, block_width_p);
  localparam int page_lsb_lp       = page_lsb_f(page_offset_width_p, block_width_p);
  localparam int page_width_lp     = line_width_lp - page_lsb_lp;

  bo_state_e                 state_q, state_d;
  logic [lg_offsets_p-1:0]   offset_q, off_q;
  logic [line_width_lp-1:0]  cand_q;
  logic [page_width_lp-1:0]  miss_page_q;
  logic [ctr_width_p-1:0]    issued_q, dropped_q;

  logic [line_width_lp-1:0]  miss_line;
  logic [line_width_lp-1:0]  cand_d;
  logic                      accept, page_cross, filter_hit, drop, handshake;
  logic                      unused_byte_bits;

  assign miss_line        = miss_addr_i[daddr_width_p-1:lg_block_bytes_lp];
  assign unused_byte_bits = ^miss_addr_i[lg_block_bytes_lp-1:0];
  // Adder wraps modulo the line space; a top-of-space wrap then shows up as a page change.
  assign cand_d           = miss_line + line_width_lp'(offset_q);
  assign accept           = (state_q == e_idle) && miss_v_i;
  assign page_cross       = (cand_q[line_width_lp-1:page_lsb_lp] != miss_page_q);

  always_comb begin
    state_d   = state_q;
    drop      = 1'b0;
    handshake = 1'b0;
    case (state_q)
      e_idle: begin
        if (miss_v_i) state_d = e_check;
      end
      e_check: begin
        if ((off_q == '0) || page_cross || filter_hit) begin
          drop    = 1'b1;
          state_d = e_idle;
        end else begin
          state_d = e_send;
        end
      end
      e_send: begin
        if (pf_ready_and_i) begin
          handshake = 1'b1;
          state_d   = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      offset_q  <= '0;
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      if (offset_v_i) offset_q  <= offset_i;
      if (drop)       dropped_q <= dropped_q + ctr_width_p'(1);
      if (handshake)  issued_q  <= issued_q + ctr_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      off_q       <= offset_q;
      cand_q      <= cand_d;
      miss_page_q <= miss_line[line_width_lp-1:page_lsb_lp];
    end
  end

  bp_me_bo_recent_filter #(
    .line_width_p   (line_width_lp),
    .lg_filter_els_p(lg_filter_els_p)
  ) filter_u (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .line_i (cand_q),
    .w_v_i  (handshake),
    .hit_o  (filter_hit)
  );

  assign miss_ready_and_o = (state_q == e_idle);
  assign pf_v_o           = (state_q == e_send);
  assign pf_addr_o        = {cand_q, {lg_block_bytes_lp{1'b0}}};
  assign issued_count_o   = issued_q;
  assign dropped_count_o  = dropped_q;

endmodule

// File: tb/tb_bp_me_bo_prefetch_issuer.sv
// Self-checking bench: directed scenarios plus randomized misses against a byte-address reference model.
module tb_bp_me_bo_prefetch_issuer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [63:0] miss_addr_i = '0;
  logic        miss_v_i = 1'b0;
  logic        miss_ready_and_o;
  logic [5:0]  offset_i = '0;
  logic        offset_v_i = 1'b0;
  logic [63:0] pf_addr_o;
  logic        pf_v_o;
  logic        pf_ready_and_i = 1'b1;
  logic [15:0] issued_count_o;
  logic [15:0] dropped_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, kept in byte addresses.
  logic [5:0]  m_offset = '0;
  logic [15:0] m_issued = '0;
  logic [15:0] m_dropped = '0;
  logic [63:0] m_filter [$];

  always #5 clk_i = ~clk_i;

  bp_me_bo_prefetch_issuer dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .miss_addr_i     (miss_addr_i),
    .miss_v_i        (miss_v_i),
    .miss_ready_and_o(miss_ready_and_o),
    .offset_i        (offset_i),
    .offset_v_i      (offset_v_i),
    .pf_addr_o       (pf_addr_o),
    .pf_v_o          (pf_v_o),
    .pf_ready_and_i  (pf_ready_and_i),
    .issued_count_o  (issued_count_o),
    .dropped_count_o (dropped_count_o)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_offset  = '0;
    m_issued  = '0;
    m_dropped = '0;
    m_filter.delete();
  endtask

  task automatic model_miss(input logic [63:0] a, output bit issue, output logic [63:0] pa);
    pa    = (a & ~64'd63) + {52'd0, m_offset, 6'd0};
    issue = (m_offset != 6'd0) && ((pa >> 12) == (a >> 12));
    foreach (m_filter[i]) if (m_filter[i] == pa) issue = 1'b0;
    if (issue) begin
      m_filter.push_back(pa);
      if (m_filter.size() > 4) void'(m_filter.pop_front());
      m_issued = m_issued + 16'd1;
    end else begin
      m_dropped = m_dropped + 16'd1;
    end
  endtask

  task automatic load_offset(input logic [5:0] o);
    offset_v_i = 1'b1;
    offset_i   = o;
    @(negedge clk_i);
    offset_v_i = 1'b0;
    m_offset   = o;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send_miss(input logic [63:0] a, input bit upd, input logic [5:0] o,
                           input int stall, input string tag);
    bit          exp_issue;
    logic [63:0] exp_addr;
    n_cmp++;
    if (miss_ready_and_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_idle: got %b want 1", tag, miss_ready_and_o);
    end
    miss_addr_i = a;
    miss_v_i    = 1'b1;
    offset_v_i  = upd;
    offset_i    = o;
    model_miss(a, exp_issue, exp_addr);
    if (upd) m_offset = o;
    @(negedge clk_i);
    miss_v_i   = 1'b0;
    offset_v_i = 1'b0;
    n_cmp++;
    if (pf_v_o !== 1'b0 || miss_ready_and_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s check_cycle: pf_v=%b ready=%b want 0/0", tag, pf_v_o, miss_ready_and_o);
    end
    pf_ready_and_i = (stall == 0);
    @(negedge clk_i);
    n_cmp++;
    if (pf_v_o !== exp_issue || (exp_issue && pf_addr_o !== exp_addr)) begin
      n_bad++;
      $display("FAIL %s pf_out: pf_v=%b addr=%h want pf_v=%b addr=%h",
               tag, pf_v_o, pf_addr_o, exp_issue, exp_addr);
    end
    if (exp_issue) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk_i);
        n_cmp++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== exp_addr || miss_ready_and_o !== 1'b0) begin
          n_bad++;
          $display("FAIL %s stall%0d: pf_v=%b addr=%h ready=%b want 1/%h/0",
                   tag, i, pf_v_o, pf_addr_o, miss_ready_and_o, exp_addr);
        end
      end
      pf_ready_and_i = 1'b1;
      @(negedge clk_i);
    end
    n_cmp++;
    if (pf_v_o !== 1'b0 || miss_ready_and_o !== 1'b1 ||
        issued_count_o !== m_issued || dropped_count_o !== m_dropped) begin
      n_bad++;
      $display("FAIL %s after: pf_v=%b ready=%b issued=%0d dropped=%0d want 0/1/%0d/%0d",
               tag, pf_v_o, miss_ready_and_o, issued_count_o, dropped_count_o, m_issued, m_dropped);
    end
    $display("%s: miss %h off %0d -> issue=%0d addr=%h stall=%0d", tag, a,
             upd ? o : m_offset, exp_issue, exp_addr, stall);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    n_cmp++;
    if (pf_v_o !== 1'b0 || miss_ready_and_o !== 1'b1 ||
        issued_count_o !== 16'd0 || dropped_count_o !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: pf_v=%b ready=%b issued=%0d dropped=%0d want 0/1/0/0",
               pf_v_o, miss_ready_and_o, issued_count_o, dropped_count_o);
    end
    $display("reset: pf_v=%b ready=%b", pf_v_o, miss_ready_and_o);
  endtask

  task automatic test_zero_offset();
    send_miss(64'h3000, 1'b0, 6'd0, 0, "zero_off");
    send_miss(64'h3000, 1'b1, 6'd5, 0, "same_cycle_offset");
    send_miss(64'h3000, 1'b0, 6'd0, 0, "new_offset");
  endtask

  task automatic test_basic();
    load_offset(6'd3);
    send_miss(64'h1000_0048, 1'b0, 6'd0, 0, "basic");
  endtask

  task automatic test_page_cross();
    load_offset(6'd2);
    send_miss(64'h0000_0FC0, 1'b0, 6'd0, 0, "page_cross");
    send_miss(64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 6'd0, 0, "top_wrap");
  endtask

  task automatic test_filter();
    load_offset(6'd1);
    send_miss(64'h2000, 1'b0, 6'd0, 0, "filter_first");
    send_miss(64'h2000, 1'b0, 6'd0, 0, "filter_hit");
    for (int i = 0; i < 5; i++)
      send_miss(64'h4000 + 64'(i) * 64'h1000, 1'b0, 6'd0, 0, "filter_fill");
    send_miss(64'h2000, 1'b0, 6'd0, 0, "filter_evicted");
  endtask

  task automatic test_backpressure();
    load_offset(6'd4);
    send_miss(64'h9000, 1'b0, 6'd0, 6, "backpressure");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [63:0] a;
      bit          upd;
      logic [5:0]  o;
      a   = 64'($urandom_range(0, 3)) * 64'h1000 + 64'($urandom_range(0, 63)) * 64'd64
          + 64'($urandom_range(0, 63));
      upd = ($urandom_range(0, 3) == 0);
      o   = 6'($urandom_range(0, 9));
      send_miss(a, upd, o, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_midsend();
    load_offset(6'd3);
    send_miss(64'h1000_0048, 1'b0, 6'd0, 0, "pre_reset");
    pf_ready_and_i = 1'b0;
    miss_addr_i    = 64'h5555_0000;
    miss_v_i       = 1'b1;
    @(negedge clk_i);
    miss_v_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (pf_v_o !== 1'b1 || pf_addr_o !== 64'h5555_00C0) begin
      n_bad++;
      $display("FAIL midsend_pending: pf_v=%b addr=%h want 1/%h", pf_v_o, pf_addr_o, 64'h5555_00C0);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (pf_v_o !== 1'b0 || issued_count_o !== 16'd0 || dropped_count_o !== 16'd0) begin
      n_bad++;
      $display("FAIL midsend_reset: pf_v=%b issued=%0d dropped=%0d want 0/0/0",
               pf_v_o, issued_count_o, dropped_count_o);
    end
    reset_i        = 1'b0;
    pf_ready_and_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    $display("midsend_reset: pf_v=%b", pf_v_o);
    load_offset(6'd3);
    send_miss(64'h1000_0048, 1'b0, 6'd0, 0, "rerun_basic");
  endtask

  initial begin
    test_reset();
    test_zero_offset();
    test_basic();
    test_page_cross();
    test_filter();
    test_backpressure();
    test_random();
    test_reset_midsend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
